// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and
// captures the returned word into the IF/ID pipeline register.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned MEM_BYTES = 72,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic [31:0] Instruction,
  output logic [63:0] Inst_Address,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [63:0] fault_addr
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [63:0] LAST_LEGAL = 64'(MEM_BYTES - 4);

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_if_id_pc;
  logic [31:0] r_if_id_inst;
  logic        r_if_id_valid;
  logic        r_fault;
  logic [63:0] r_fault_addr;

  state_t      w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic [63:0] w_if_id_pc_nxt;
  logic [31:0] w_if_id_inst_nxt;
  logic        w_if_id_valid_nxt;
  logic        w_fault_nxt;
  logic [63:0] w_fault_addr_nxt;
  logic        w_illegal;

  assign w_illegal = (r_pc[1:0] != 2'b00) || (r_pc > LAST_LEGAL);

  // Next-state and next-register values; branch beats stall beats fault check.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_id_pc_nxt    = r_if_id_pc;
    w_if_id_inst_nxt  = r_if_id_inst;
    w_if_id_valid_nxt = r_if_id_valid;
    w_fault_nxt       = r_fault;
    w_fault_addr_nxt  = r_fault_addr;
    case (r_state)
      BOOT: begin
        w_state_nxt       = RUN;
        w_if_id_valid_nxt = 1'b0;
      end
      RUN: begin
        if (branch_taken) begin
          w_pc_nxt          = branch_target;
          w_if_id_valid_nxt = 1'b0;
          w_if_id_inst_nxt  = NOP_INST;
          w_if_id_pc_nxt    = '0;
        end else if (stall) begin
          w_pc_nxt = r_pc;
        end else if (w_illegal) begin
          w_state_nxt       = FAULT;
          w_fault_nxt       = 1'b1;
          w_fault_addr_nxt  = r_pc;
          w_if_id_valid_nxt = 1'b0;
          w_if_id_inst_nxt  = NOP_INST;
        end else begin
          w_if_id_pc_nxt    = r_pc;
          w_if_id_inst_nxt  = Instruction;
          w_if_id_valid_nxt = 1'b1;
          w_pc_nxt          = r_pc + 64'd4;
        end
      end
      FAULT: begin
        w_if_id_valid_nxt = 1'b0;
        w_fault_nxt       = 1'b1;
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_addr  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_id_pc    <= w_if_id_pc_nxt;
      r_if_id_inst  <= w_if_id_inst_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_fault       <= w_fault_nxt;
      r_fault_addr  <= w_fault_addr_nxt;
    end
  end

  assign Inst_Address = r_pc;
  assign if_id_pc     = r_if_id_pc;
  assign if_id_inst   = r_if_id_inst;
  assign if_id_valid  = r_if_id_valid;
  assign fetch_fault  = r_fault;
  assign fault_addr   = r_fault_addr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch stage with a combinational memory model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic [31:0] Instruction;
  logic [63:0] Inst_Address;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [63:0] fault_addr;

  int total = 0;
  int bad = 0;

  // {valid, pc, inst} packed for compact comparisons
  logic [96:0] obs_ifid;
  logic [96:0] exp_ifid;

  instruction_fetch_unit #(
    .RESET_PC (64'h0),
    .MEM_BYTES(72),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .Instruction  (Instruction),
    .Inst_Address (Inst_Address),
    .if_id_pc     (if_id_pc),
    .if_id_inst   (if_id_inst),
    .if_id_valid  (if_id_valid),
    .fetch_fault  (fetch_fault),
    .fault_addr   (fault_addr)
  );

  always #5 clk = ~clk;

  assign Instruction = 32'hC0DE_0000 | {16'h0, Inst_Address[15:0]};
  assign obs_ifid    = {if_id_valid, if_id_pc, if_id_inst};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected reset values of every output
  task automatic chk_reset_vals(input string tag);
    total++;
    if (obs_ifid !== {1'b0, 64'h0, 32'h0000_0013}) begin
      bad++;
      $display("FAIL %s_ifid got=%h want=%h", tag, obs_ifid, {1'b0, 64'h0, 32'h0000_0013});
    end
    total++;
    if ({fetch_fault, fault_addr, Inst_Address} !== {1'b0, 64'h0, 64'h0}) begin
      bad++;
      $display("FAIL %s_fault_pc got=%b/%h/%h want=0/0/0", tag, fetch_fault, fault_addr, Inst_Address);
    end
  endtask

  task automatic test_reset_and_run();
    reset = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b1;
    tick();
    total++;
    if (if_id_valid !== 1'b0 || Inst_Address !== 64'h0) begin
      bad++;
      $display("FAIL boot_bubble got=%b/%h want=0/0", if_id_valid, Inst_Address);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      exp_ifid = {1'b1, 64'(k * 4), 32'hC0DE_0000 | 32'(k * 4)};
      total++;
      if (obs_ifid !== exp_ifid) begin
        bad++;
        $display("FAIL run_%0d got=%h want=%h", k, obs_ifid, exp_ifid);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      total++;
      if (obs_ifid !== {1'b1, 64'h0C, 32'hC0DE_000C} || Inst_Address !== 64'h10) begin
        bad++;
        $display("FAIL stall_%0d got=%h/%h want=%h/10", k, obs_ifid, Inst_Address,
                 {1'b1, 64'h0C, 32'hC0DE_000C});
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (obs_ifid !== {1'b1, 64'h10, 32'hC0DE_0010}) begin
      bad++;
      $display("FAIL stall_resume got=%h want=%h", obs_ifid, {1'b1, 64'h10, 32'hC0DE_0010});
    end
  endtask

  task automatic test_branch_stall();
    branch_taken  = 1'b1;
    branch_target = 64'h20;
    stall         = 1'b1;
    tick();
    branch_taken = 1'b0;
    stall        = 1'b0;
    total++;
    if (obs_ifid !== {1'b0, 64'h0, 32'h0000_0013} || Inst_Address !== 64'h20) begin
      bad++;
      $display("FAIL branch_bubble got=%h/%h want=%h/20", obs_ifid, Inst_Address,
               {1'b0, 64'h0, 32'h0000_0013});
    end
    tick();
    total++;
    if (obs_ifid !== {1'b1, 64'h20, 32'hC0DE_0020}) begin
      bad++;
      $display("FAIL branch_target got=%h want=%h", obs_ifid, {1'b1, 64'h20, 32'hC0DE_0020});
    end
  endtask

  task automatic test_bad_redirect();
    branch_taken  = 1'b1;
    branch_target = 64'h22;
    tick();
    branch_taken = 1'b0;
    total++;
    if (if_id_valid !== 1'b0 || fetch_fault !== 1'b0 || Inst_Address !== 64'h22) begin
      bad++;
      $display("FAIL misalign_bubble got=%b/%b/%h want=0/0/22", if_id_valid, fetch_fault, Inst_Address);
    end
    tick();
    total++;
    if ({fetch_fault, fault_addr, if_id_valid} !== {1'b1, 64'h22, 1'b0}) begin
      bad++;
      $display("FAIL misalign_fault got=%b/%h/%b want=1/22/0", fetch_fault, fault_addr, if_id_valid);
    end
    branch_taken  = 1'b1;
    branch_target = 64'h0;
    tick();
    tick();
    branch_taken = 1'b0;
    total++;
    if ({fetch_fault, fault_addr, if_id_valid, Inst_Address} !== {1'b1, 64'h22, 1'b0, 64'h22}) begin
      bad++;
      $display("FAIL fault_sticky got=%b/%h/%b/%h want=1/22/0/22", fetch_fault, fault_addr,
               if_id_valid, Inst_Address);
    end
  endtask

  task automatic test_reset_in_fault();
    reset = 1'b0;
    tick();
    chk_reset_vals("rst_fault");
    reset         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 64'h30;
    tick();
    branch_taken = 1'b0;
    total++;
    if (if_id_valid !== 1'b0 || Inst_Address !== 64'h0) begin
      bad++;
      $display("FAIL boot_ignores_branch got=%b/%h want=0/0", if_id_valid, Inst_Address);
    end
    tick();
    total++;
    if (obs_ifid !== {1'b1, 64'h0, 32'hC0DE_0000}) begin
      bad++;
      $display("FAIL rst_fault_resume got=%h want=%h", obs_ifid, {1'b1, 64'h0, 32'hC0DE_0000});
    end
  endtask

  task automatic test_seq_fault();
    branch_taken  = 1'b1;
    branch_target = 64'h40;
    tick();
    branch_taken = 1'b0;
    tick();
    total++;
    if (obs_ifid !== {1'b1, 64'h40, 32'hC0DE_0040}) begin
      bad++;
      $display("FAIL seq_40 got=%h want=%h", obs_ifid, {1'b1, 64'h40, 32'hC0DE_0040});
    end
    tick();
    total++;
    if (obs_ifid !== {1'b1, 64'h44, 32'hC0DE_0044}) begin
      bad++;
      $display("FAIL seq_44 got=%h want=%h", obs_ifid, {1'b1, 64'h44, 32'hC0DE_0044});
    end
    tick();
    total++;
    if ({fetch_fault, fault_addr, if_id_valid} !== {1'b1, 64'h48, 1'b0}) begin
      bad++;
      $display("FAIL seq_limit_fault got=%b/%h/%b want=1/48/0", fetch_fault, fault_addr, if_id_valid);
    end
  endtask

  task automatic test_reset_in_stall();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk_reset_vals("rst_stall");
    reset = 1'b1;
    stall = 1'b0;
    tick();
    total++;
    if (if_id_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_stall_boot got=%b want=0", if_id_valid);
    end
    tick();
    total++;
    if (obs_ifid !== {1'b1, 64'h0, 32'hC0DE_0000}) begin
      bad++;
      $display("FAIL rst_stall_resume got=%h want=%h", obs_ifid, {1'b1, 64'h0, 32'hC0DE_0000});
    end
  endtask

  initial begin
    test_reset_and_run();
    test_stall();
    test_branch_stall();
    test_bad_redirect();
    test_reset_in_fault();
    test_seq_fault();
    test_reset_in_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
